rewind_seq: RTL and testbench

REWIND_SEQ -- requirements
Module: rewind_seq

---
 rtl/rewind_seq.sv | 85 ++++++++
 tb/tb_rewind_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rewind_seq.sv
// ROB rollback walker: after a squash, streams the squashed entries youngest-to-oldest,
// up to WAY per cycle, so rename state can be restored from each entry's T/Told.
module rewind_seq #(
  parameter int WAY        = 2,
  parameter int ROB_SZ     = 32,
  parameter int PHY_REG_SZ = 64,
  localparam int RI = $clog2(ROB_SZ),
  localparam int PI = $clog2(PHY_REG_SZ),
  localparam int CW = $clog2(WAY) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash_valid,
  input  logic [RI-1:0]           squash_rob_idx,
  input  logic [RI-1:0]           rob_tail,
  input  logic                    hold,
  output logic [WAY-1:0][RI-1:0]  rd_idx,
  input  logic [WAY-1:0][PI-1:0]  rd_T,
  input  logic [WAY-1:0][PI-1:0]  rd_Told,
  output logic [CW-1:0]           rw_num,
  output logic [WAY-1:0][RI-1:0]  rw_rob_index,
  output logic [WAY-1:0][PI-1:0]  rw_reg_T,
  output logic [WAY-1:0][PI-1:0]  rw_reg_Told,
  output logic                    busy,
  output logic                    done,
  output logic [RI-1:0]           new_tail
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

  state_t        state_q;
  logic [RI-1:0] ptr_q, rem_q, new_tail_q;
  logic [RI-1:0] sq_rem_d, step_d, ptr_d, rem_d;
  logic          beat_d;

  always_comb begin
    // Entries strictly younger than the branch; natural RI-bit wrap gives the modulo.
    sq_rem_d = rob_tail - squash_rob_idx - RI'(1);
    step_d   = (rem_q < RI'(WAY)) ? rem_q : RI'(WAY);
    beat_d   = (state_q == S_WALK) && !hold;
    ptr_d    = ptr_q - step_d;
    rem_d    = rem_q - step_d;
    for (int i = 0; i < WAY; i++) begin
      rd_idx[i] = ptr_q - RI'(i);
    end
  end

  assign rw_num       = beat_d ? CW'(step_d) : '0;
  assign rw_rob_index = rd_idx;
  assign rw_reg_T     = rd_T;
  assign rw_reg_Told  = rd_Told;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign new_tail     = new_tail_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      new_tail_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (squash_valid) begin
            ptr_q      <= rob_tail - RI'(1);
            rem_q      <= sq_rem_d;
            new_tail_q <= squash_rob_idx + RI'(1);
            state_q    <= (sq_rem_d != '0) ? S_WALK : S_DONE;
          end
        end
        S_WALK: begin
          if (beat_d) begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
            if (rem_d == '0) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rewind_seq.sv
// Directed bench for rewind_seq (WAY=2, ROB_SZ=32): per-cycle expectations of the rollback walk.
module tb_rewind_seq;
  localparam int WAY = 2, ROB_SZ = 32, PHY = 64, RI = 5, PI = 6, CW = 2;

  logic clock = 1'b0;
  logic reset, squash_valid, hold;
  logic [RI-1:0] squash_rob_idx, rob_tail, new_tail;
  logic [WAY-1:0][RI-1:0] rd_idx, rw_rob_index;
  logic [WAY-1:0][PI-1:0] rd_T, rd_Told, rw_reg_T, rw_reg_Told;
  logic [CW-1:0] rw_num;
  logic busy, done;
  int total = 0, fails = 0;

  rewind_seq #(.WAY(WAY), .ROB_SZ(ROB_SZ), .PHY_REG_SZ(PHY)) dut (
    .clock(clock), .reset(reset), .squash_valid(squash_valid),
    .squash_rob_idx(squash_rob_idx), .rob_tail(rob_tail), .hold(hold),
    .rd_idx(rd_idx), .rd_T(rd_T), .rd_Told(rd_Told), .rw_num(rw_num),
    .rw_rob_index(rw_rob_index), .rw_reg_T(rw_reg_T), .rw_reg_Told(rw_reg_Told),
    .busy(busy), .done(done), .new_tail(new_tail));

  always #5 clock = ~clock;

  // ROB contents: T = {1, idx}, Told = {0, ~idx}
  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      rd_T[i]    = {1'b1, rd_idx[i]};
      rd_Told[i] = {1'b0, ~rd_idx[i]};
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Observed {busy, done, rw_num, slot0 idx, slot1 idx}, don't-care slots zeroed.
  function automatic logic [13:0] snap();
    logic [4:0] a, b;
    a = (rw_num > 0) ? rw_rob_index[0] : 5'd0;
    b = (rw_num > 1) ? rw_rob_index[1] : 5'd0;
    return {busy, done, rw_num, a, b};
  endfunction

  function automatic logic [13:0] ev(logic b, logic d, logic [1:0] n, logic [4:0] i0, logic [4:0] i1);
    return {b, d, n, (n > 0) ? i0 : 5'd0, (n > 1) ? i1 : 5'd0};
  endfunction

  task automatic issue(input logic [4:0] idx, input logic [4:0] tail);
    squash_valid = 1'b1; squash_rob_idx = idx; rob_tail = tail;
    cyc();
    squash_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; squash_valid = 1'b1; hold = 1'b0; squash_rob_idx = 5'd3; rob_tail = 5'd9;
    cyc(); cyc();
    reset = 1'b0; squash_valid = 1'b0;
    total++;
    if ({busy, done, rw_num} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got=%b want=0000", {busy, done, rw_num});
    end
    total++;
    if ({rd_idx[0], rd_idx[1], new_tail} !== {5'd0, 5'd31, 5'd0}) begin
      fails++; $display("FAIL reset_ptr got=%0d,%0d,%0d want=0,31,0", rd_idx[0], rd_idx[1], new_tail);
    end
  endtask

  task automatic test_basic();
    logic [13:0] e [4];
    e[0] = ev(1, 0, 2, 9, 8); e[1] = ev(1, 0, 2, 7, 6); e[2] = ev(1, 1, 0, 0, 0); e[3] = ev(0, 0, 0, 0, 0);
    issue(5'd5, 5'd10);
    total++;
    if ({rw_reg_T[0], rw_reg_Told[1]} !== {6'd41, 6'd23}) begin
      fails++; $display("FAIL basic_T got=%0d,%0d want=41,23", rw_reg_T[0], rw_reg_Told[1]);
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (snap() !== e[c]) begin fails++; $display("FAIL basic c%0d got=%h want=%h", c, snap(), e[c]); end
      if (c == 2) begin
        total++;
        if (new_tail !== 5'd6) begin fails++; $display("FAIL basic_tail got=%0d want=6", new_tail); end
      end
      cyc();
    end
  endtask

  task automatic test_odd();
    logic [13:0] e [4];
    e[0] = ev(1, 0, 2, 8, 7); e[1] = ev(1, 0, 1, 6, 0); e[2] = ev(1, 1, 0, 0, 0); e[3] = ev(0, 0, 0, 0, 0);
    issue(5'd5, 5'd9);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (snap() !== e[c]) begin fails++; $display("FAIL odd c%0d got=%h want=%h", c, snap(), e[c]); end
      cyc();
    end
  endtask

  task automatic test_wrap();
    logic [13:0] e [4];
    e[0] = ev(1, 0, 2, 1, 0); e[1] = ev(1, 0, 1, 31, 0); e[2] = ev(1, 1, 0, 0, 0); e[3] = ev(0, 0, 0, 0, 0);
    issue(5'd30, 5'd2);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (snap() !== e[c]) begin fails++; $display("FAIL wrap c%0d got=%h want=%h", c, snap(), e[c]); end
      if (c == 2) begin
        total++;
        if (new_tail !== 5'd31) begin fails++; $display("FAIL wrap_tail got=%0d want=31", new_tail); end
      end
      cyc();
    end
  endtask

  task automatic test_empty();
    issue(5'd7, 5'd8);
    total++;
    if ({snap(), new_tail} !== {ev(1, 1, 0, 0, 0), 5'd8}) begin
      fails++; $display("FAIL empty_done got=%h/%0d want=%h/8", snap(), new_tail, ev(1, 1, 0, 0, 0));
    end
    cyc();
    total++;
    if (snap() !== ev(0, 0, 0, 0, 0)) begin fails++; $display("FAIL empty_idle got=%h", snap()); end
  endtask

  task automatic test_full();
    logic [13:0] e;
    issue(5'd0, 5'd0);
    for (int c = 0; c < 18; c++) begin
      if (c < 15)       e = ev(1, 0, 2, 5'(31 - 2 * c), 5'(30 - 2 * c));
      else if (c == 15) e = ev(1, 0, 1, 5'd1, 5'd0);
      else if (c == 16) e = ev(1, 1, 0, 0, 0);
      else              e = ev(0, 0, 0, 0, 0);
      total++;
      if (snap() !== e) begin fails++; $display("FAIL full c%0d got=%h want=%h", c, snap(), e); end
      if (c == 16) begin
        total++;
        if (new_tail !== 5'd1) begin fails++; $display("FAIL full_tail got=%0d want=1", new_tail); end
      end
      cyc();
    end
  endtask

  task automatic test_hold();
    logic [13:0] e [5];
    e[0] = ev(1, 0, 2, 9, 8); e[1] = ev(1, 0, 0, 0, 0); e[2] = ev(1, 0, 2, 7, 6);
    e[3] = ev(1, 1, 0, 0, 0); e[4] = ev(0, 0, 0, 0, 0);
    issue(5'd5, 5'd10);
    for (int c = 0; c < 5; c++) begin
      squash_valid = (c == 0); squash_rob_idx = 5'd20; rob_tail = 5'd25;
      hold = (c == 1);
      #1;
      total++;
      if (snap() !== e[c]) begin fails++; $display("FAIL hold c%0d got=%h want=%h", c, snap(), e[c]); end
      if (c == 1) begin
        total++;
        if ({rd_idx[0], rd_idx[1]} !== {5'd7, 5'd6}) begin
          fails++; $display("FAIL hold_rd got=%0d,%0d want=7,6", rd_idx[0], rd_idx[1]);
        end
      end
      if (c == 3) begin
        total++;
        if (new_tail !== 5'd6) begin fails++; $display("FAIL hold_tail got=%0d want=6", new_tail); end
      end
      cyc();
    end
    squash_valid = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(5'd5, 5'd10);
    total++;
    if (snap() !== ev(1, 0, 2, 9, 8)) begin fails++; $display("FAIL rstmid_beat got=%h", snap()); end
    reset = 1'b1; squash_valid = 1'b1; squash_rob_idx = 5'd5; rob_tail = 5'd10;
    cyc();
    reset = 1'b0; squash_valid = 1'b0;
    #1;
    total++;
    if ({snap(), rd_idx[0], new_tail} !== {ev(0, 0, 0, 0, 0), 5'd0, 5'd0}) begin
      fails++; $display("FAIL rstmid_after got=%h/%0d/%0d want=%h/0/0", snap(), rd_idx[0], new_tail, ev(0, 0, 0, 0, 0));
    end
    cyc();
    total++;
    if (snap() !== ev(0, 0, 0, 0, 0)) begin fails++; $display("FAIL rstmid_drop got=%h", snap()); end
    issue(5'd5, 5'd9);
    total++;
    if (snap() !== ev(1, 0, 2, 8, 7)) begin fails++; $display("FAIL rstmid_fresh got=%h want=%h", snap(), ev(1, 0, 2, 8, 7)); end
    cyc(); cyc(); cyc();
    total++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_end got=%b want=0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_wrap();
    test_empty();
    test_full();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
